// File: rtl/parity_pkg.sv
// Shared types and parity helper for the parity-protected 32-bit FIFO.
package parity_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic              par;
    logic [WORD_W-1:0] data;
  } par_word_t;

  // Odd parity: data plus the returned bit always holds an odd number of ones.
  function automatic logic odd_par(input logic [WORD_W-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/par_gen_odd32.sv
// Combinational odd-parity generator; used at the write port and as the read-side checker.
module par_gen_odd32
  import parity_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  output logic              par_o
);

  assign par_o = odd_par(data_i);

endmodule

// File: rtl/parity_fifo32.sv
// Parity-protected first-word-fall-through FIFO with sticky/saturating error accounting.
// Define PARITY_FIFO32_ERR_INJECT_EN to add the err_inject port (stored parity inversion on push).
module parity_fifo32
  import parity_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int ECNT_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
`ifdef PARITY_FIFO32_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_parity,
  input  logic              rd_ready,
  output logic              rd_perr,
  output logic              err_sticky,
  output logic [ECNT_W-1:0] err_cnt,
  input  logic              err_clr,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  par_word_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;

  logic      push_s, pop_s;
  logic      wr_par_s, chk_par_s;
  par_word_t wr_entry_s, head_s;

  assign wr_ready = (count_q != FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign push_s   = wr_valid & wr_ready;
  assign pop_s    = rd_valid & rd_ready;

  par_gen_odd32 u_wr_gen (
    .data_i (wr_data),
    .par_o  (wr_par_s)
  );

`ifdef PARITY_FIFO32_ERR_INJECT_EN
  assign wr_entry_s.par = wr_par_s ^ err_inject;
`else
  assign wr_entry_s.par = wr_par_s;
`endif
  assign wr_entry_s.data = wr_data;

  assign head_s = mem_q[rd_ptr_q];

  // The same generator recomputes parity of the head word; a mismatch is an even ones-count.
  par_gen_odd32 u_rd_chk (
    .data_i (head_s.data),
    .par_o  (chk_par_s)
  );

  assign rd_data   = rd_valid ? head_s.data : '0;
  assign rd_parity = rd_valid ? head_s.par  : 1'b0;
  assign rd_perr   = rd_valid & (head_s.par != chk_par_s);

  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign count      = count_q;

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Next-state for pointers, occupancy and error accounting.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear wins over an error event in the same cycle.
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (pop_s && rd_perr) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule
